// File: rtl/spi_master_rx_pkg.sv
// Shared SPI definitions for the camera link: widths, FSM states and the
// slave-side SPI mode. The camera-side slave transmitter imports this too.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_CNT_W  = 16;

    // Mode 1: sck idles low, slave launches on the rising edge, master
    // samples on the falling edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // Width of a down-counter able to hold the largest of three cycle counts.
    function automatic int spi_tmr_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/spi_master_rx_sck_gen.sv
// sck divider for the SPI master. While idle the divider sits at its
// terminal count, so the first cycle with run=1 issues a rising edge
// immediately; afterwards sck toggles every CLK_DIV cycles.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic run,
    input  logic force_low,
    output logic sck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int              DIV_W  = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             toggle;

    // Strobes describe the toggle that the coming sys_clk edge will perform.
    assign toggle   = run && !force_low && (div_cnt == DIV_TC);
    assign rise_stb = toggle && !sck;
    assign fall_stb = toggle && sck;

    // Divider counter and sck register; idle/forced state parks sck low.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (force_low || !run) begin
            div_cnt <= DIV_TC;
            sck     <= 1'b0;
        end else if (toggle) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_rx.sv
// SPI master receiver for the camera link. Reads frame_len bytes, MSB-first,
// under one cs_n assertion and hands each byte to the packet buffer with a
// one-cycle data_valid strobe.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cs_n high, waiting for start
// SETUP | cs_n low, counting cs-to-first-sck-rise; last cycle issues the rise
// SHIFT | sck running, bits sampled on each sck fall
// HOLD  | sck parked low, cs_n held low for CS_HOLD cycles
// GAP   | cs_n high, minimum inter-frame gap before returning to IDLE
module spi_master_rx
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [SPI_CNT_W-1:0]  frame_len,
    input  logic                  abort,
    output logic                  sck,
    output logic                  cs_n,
    input  logic                  miso,
    output logic [SPI_BYTE_W-1:0] data_out,
    output logic                  data_valid,
    output logic [SPI_CNT_W-1:0]  byte_cnt,
    output logic                  busy,
    output logic                  done
);

    localparam int TMR_W = spi_tmr_w(CS_SETUP, CS_HOLD, CS_GAP);
    localparam int BIT_W = $clog2(SPI_BYTE_W);

    spi_state_e state_q, state_d;

    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic                  tmr_tc;
    logic [SPI_CNT_W-1:0]  len_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    // Only the first seven bits need storing; the eighth comes straight off miso.
    logic [SPI_BYTE_W-2:0] shift_reg_q;

    logic accept;
    logic abort_act;
    logic run;
    logic force_low;
    logic rise_stb;
    logic fall_stb;
    logic last_bit;
    logic byte_done;
    logic frame_end;
    logic cs_n_d;
    logic busy_d;
    logic done_d;

    assign tmr_tc    = (tmr_q == '0);
    assign accept    = (state_q == IDLE) && start && (frame_len != '0);
    assign abort_act = abort && ((state_q == SETUP) || (state_q == SHIFT));
    assign force_low = abort_act;
    // The divider is armed on the final SETUP cycle so the first rise lands
    // exactly CS_SETUP cycles after cs_n falls.
    assign run       = (state_q == SHIFT) || ((state_q == SETUP) && tmr_tc);
    assign last_bit  = fall_stb && (bit_cnt_q == BIT_W'(SPI_BYTE_W - 1));
    assign byte_done = last_bit && !abort_act;
    assign frame_end = byte_done && ((byte_cnt + SPI_CNT_W'(1)) == len_q);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .run       (run),
        .force_low (force_low),
        .sck       (sck),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb)
    );

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; abort only matters while cs_n is low and sck may run.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = SETUP;
            SETUP: begin
                if (abort)         state_d = HOLD;
                else if (rise_stb) state_d = SHIFT;
            end
            SHIFT: begin
                if (abort)          state_d = HOLD;
                else if (frame_end) state_d = HOLD;
            end
            HOLD:  if (tmr_tc) state_d = GAP;
            GAP:   if (tmr_tc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs and phase timer.
    always_comb begin
        cs_n_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
        busy_d = (state_d != IDLE);
        done_d = ((state_q == IDLE) && start && (frame_len == '0))
              || ((state_q == HOLD) && tmr_tc);
        tmr_d  = tmr_q;
        if (state_d != state_q) begin
            unique case (state_d)
                SETUP:   tmr_d = TMR_W'(CS_SETUP - 1);
                HOLD:    tmr_d = TMR_W'(CS_HOLD - 1);
                GAP:     tmr_d = TMR_W'(CS_GAP - 1);
                default: tmr_d = '0;
            endcase
        end else if (!tmr_tc) begin
            tmr_d = tmr_q - TMR_W'(1);
        end
    end

    // Registered outputs, phase timer, shift register and byte/bit counters.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cs_n        <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            data_valid  <= 1'b0;
            data_out    <= '0;
            byte_cnt    <= '0;
            tmr_q       <= '0;
            len_q       <= '0;
            bit_cnt_q   <= '0;
            shift_reg_q <= '0;
        end else begin
            cs_n       <= cs_n_d;
            busy       <= busy_d;
            done       <= done_d;
            tmr_q      <= tmr_d;
            data_valid <= byte_done;
            if (accept) begin
                len_q     <= frame_len;
                byte_cnt  <= '0;
                bit_cnt_q <= '0;
            end
            if (force_low) begin
                bit_cnt_q <= '0;
            end else if (fall_stb) begin
                shift_reg_q <= {shift_reg_q[SPI_BYTE_W-3:0], miso};
                bit_cnt_q   <= bit_cnt_q + BIT_W'(1);
            end
            if (byte_done) begin
                data_out <= {shift_reg_q, miso};
                byte_cnt <= byte_cnt + SPI_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_master_rx.sv
// Bench for spi_master_rx with a behavioural mode-1 slave. Expected bytes are
// queued when a frame is issued and checked by a negedge monitor as data_valid
// strobes arrive; the same monitor logs sck/cs_n/done event cycles for timing checks.
module tb_spi_master_rx;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start   = 1'b0;
    logic [15:0] frame_len = 16'd0;
    logic        abort   = 1'b0;
    logic        miso    = 1'b0;
    logic        sck;
    logic        cs_n;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [15:0] byte_cnt;
    logic        busy;
    logic        done;

    spi_master_rx dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .frame_len  (frame_len),
        .abort      (abort),
        .sck        (sck),
        .cs_n       (cs_n),
        .miso       (miso),
        .data_out   (data_out),
        .data_valid (data_valid),
        .byte_cnt   (byte_cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] slv_bytes[$];
    int         vcyc[$];

    int cyc = 0;
    int n_rise, n_fall, n_csfall, n_done, n_valid;
    int first_rise, last_fall, cs_fall, cs_rise, done_cyc, ab_cyc;
    logic sck_prev = 1'b0;
    logic cs_prev  = 1'b1;
    logic [7:0] sb_exp;

    // Slave: MSB-first, launches the next bit on each sck rise while selected.
    int         slv_byte = 0;
    int         slv_bit  = 7;
    logic [7:0] slv_cur;
    always @(negedge cs_n) begin
        slv_byte = 0;
        slv_bit  = 7;
    end
    always @(posedge sck) begin
        if (cs_n === 1'b0) begin
            slv_cur = (slv_byte < slv_bytes.size()) ? slv_bytes[slv_byte] : 8'h00;
            miso = slv_cur[slv_bit];
            if (slv_bit == 0) begin
                slv_bit = 7;
                slv_byte++;
            end else begin
                slv_bit--;
            end
        end
    end

    // Monitor: event logging plus scoreboard check of each received byte.
    always @(negedge sys_clk) begin
        cyc++;
        if (sck === 1'b1 && sck_prev === 1'b0) begin
            n_rise++;
            if (first_rise < 0) first_rise = cyc;
        end
        if (sck === 1'b0 && sck_prev === 1'b1) begin
            n_fall++;
            last_fall = cyc;
        end
        if (cs_n === 1'b0 && cs_prev === 1'b1) begin
            n_csfall++;
            cs_fall = cyc;
        end
        if (cs_n === 1'b1 && cs_prev === 1'b0) cs_rise = cyc;
        if (done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (abort === 1'b1) ab_cyc = cyc;
        if (data_valid === 1'b1) begin
            n_valid++;
            vcyc.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: data_out=%02h but no byte expected", data_out);
            end else begin
                sb_exp = exp_q.pop_front();
                if (data_out !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_byte: data_out=%02h expected=%02h", data_out, sb_exp);
                end
            end
        end
        sck_prev = sck;
        cs_prev  = cs_n;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_rise = 0; n_fall = 0; n_csfall = 0; n_done = 0; n_valid = 0;
        first_rise = -1; last_fall = -1; cs_fall = -1; cs_rise = -1;
        done_cyc = -1; ab_cyc = -1;
        vcyc.delete();
    endtask

    task automatic pulse_start(input logic [15:0] len);
        @(posedge sys_clk); #1;
        start = 1'b1;
        frame_len = len;
        @(posedge sys_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge sys_clk);
            if (done === 1'b1) break;
        end
        total++;
        if (k >= budget) begin
            bad++;
            $display("FAIL %s: done not seen within %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_falls(input string nm, input int n, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge sys_clk);
            if (n_fall >= n) break;
        end
        total++;
        if (k >= budget) begin
            bad++;
            $display("FAIL %s: %0d sck falls not seen, got %0d", nm, n, n_fall);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        clear_stats();

        // 1: reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_sck",   sck, 0);
        chk("rst_cs_n",  cs_n, 1);
        chk("rst_busy",  busy, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_bcnt",  byte_cnt, 0);
        chk("rst_done",  done, 0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);

        // 2: single byte 0xA5
        clear_stats();
        slv_bytes = '{8'hA5};
        exp_q.push_back(8'hA5);
        pulse_start(16'd1);
        @(negedge sys_clk);
        chk("t2_busy", busy, 1);
        wait_done("t2_done", 500);
        repeat (12) @(posedge sys_clk);
        chk("t2_rises",   n_rise, 8);
        chk("t2_falls",   n_fall, 8);
        chk("t2_valids",  n_valid, 1);
        chk("t2_setup",   first_rise - cs_fall, 4);
        chk("t2_hold",    done_cyc - last_fall, 4);
        chk("t2_bcnt",    byte_cnt, 1);
        chk("t2_ndone",   n_done, 1);
        chk("t2_idle",    busy, 0);

        // 3: four bytes
        clear_stats();
        slv_bytes = '{8'h00, 8'hFF, 8'h5A, 8'hC3};
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        pulse_start(16'd4);
        wait_done("t3_done", 1000);
        repeat (12) @(posedge sys_clk);
        chk("t3_valids", n_valid, 4);
        if (vcyc.size() == 4) begin
            for (int i = 0; i < 3; i++) chk("t3_spacing", vcyc[i+1] - vcyc[i], 64);
        end
        chk("t3_bcnt",   byte_cnt, 4);
        chk("t3_csfall", n_csfall, 1);
        chk("t3_rises",  n_rise, 32);

        // 4: frame_len = 0
        clear_stats();
        pulse_start(16'd0);
        @(negedge sys_clk);
        chk("t4_done_hi", done, 1);
        @(negedge sys_clk);
        chk("t4_done_lo", done, 0);
        repeat (10) @(posedge sys_clk);
        chk("t4_csfall", n_csfall, 0);
        chk("t4_rises",  n_rise, 0);
        chk("t4_busy",   busy, 0);
        chk("t4_ndone",  n_done, 1);

        // 5: abort after 12 falls of a 3-byte frame
        clear_stats();
        slv_bytes = '{8'h96, 8'h22, 8'h33};
        exp_q.push_back(8'h96);
        pulse_start(16'd3);
        wait_falls("t5_falls12", 12, 400);
        @(posedge sys_clk); #1;
        abort = 1'b1;
        @(posedge sys_clk); #1;
        abort = 1'b0;
        @(negedge sys_clk);
        chk("t5_sck_low", sck, 0);
        wait_done("t5_done", 100);
        repeat (12) @(posedge sys_clk);
        chk("t5_valids",  n_valid, 1);
        chk("t5_bcnt",    byte_cnt, 1);
        chk("t5_falls",   n_fall, 12);
        chk("t5_rises",   n_rise, 12);
        // abort seen at the negedge before the sampling edge, cs_n up CS_HOLD edges later
        chk("t5_cs_hold", cs_rise - ab_cyc, 5);
        chk("t5_done_at", done_cyc - cs_rise, 0);
        chk("t5_ndone",   n_done, 1);

        // 6: reset mid-frame, then start during GAP
        clear_stats();
        slv_bytes = '{8'h01, 8'h02, 8'h03};
        exp_q.push_back(8'h01);
        pulse_start(16'd3);
        wait_falls("t6_falls12", 12, 400);
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("t6_sck",   sck, 0);
        chk("t6_cs_n",  cs_n, 1);
        chk("t6_busy",  busy, 0);
        chk("t6_bcnt",  byte_cnt, 0);
        chk("t6_valid", data_valid, 0);
        repeat (20) @(posedge sys_clk);
        chk("t6_nodone", n_done, 0);
        chk("t6_valids", n_valid, 1);

        clear_stats();
        slv_bytes = '{8'h3C};
        exp_q.push_back(8'h3C);
        pulse_start(16'd1);
        wait_done("t6_done", 500);
        pulse_start(16'd2);
        @(negedge sys_clk);
        chk("t6_gap_busy", busy, 1);
        chk("t6_gap_cs_n", cs_n, 1);
        for (k = 0; k < 50; k++) begin
            @(negedge sys_clk);
            if (busy === 1'b0) break;
        end
        chk("t6_busy_drop", busy, 0);
        repeat (10) @(posedge sys_clk);
        chk("t6_csfall", n_csfall, 1);
        chk("t6_idle_cs", cs_n, 1);
        chk("t6_idle",   busy, 0);
        chk("t6_valids2", n_valid, 1);
        chk("t6_ndone",  n_done, 1);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
